// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial adder controller: state encoding and default width.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int N_DEF = 8;

endpackage

// File: rtl/serial_add_ctrl_bit_counter.sv
// Bit-index counter: sync clear, enable, and terminal-count flag at N-1 (wraps to 0).
module bit_counter #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);

    logic [CW-1:0] r_count;
    logic          w_tc;

    assign w_tc    = (r_count == CW'(N - 1));
    assign o_count = r_count;
    assign o_tc    = w_tc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr || (i_en && w_tc)) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencing FSM for the bit-serial adder: load, N add cycles, done pulse, registered carry-out.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_carry_d,
    output logic          o_ld_A,
    output logic          o_ld_B,
    output logic          o_shift,
    output logic          o_carry_clr,
    output logic          o_carry_en,
    output logic          o_sum_shift,
    output logic [CW-1:0] o_bit_idx,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_cout
);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] w_count;
    logic          w_tc;
    logic          w_cnt_clr;
    logic          w_cnt_en;
    logic          r_cout;

    bit_counter #(
        .N  (N),
        .CW (CW)
    ) u_bit_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_count),
        .o_tc    (w_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs depend only on registered state/count, so no input reaches an output combinationally.
    always_comb begin
        w_next      = r_state;
        o_ld_A      = 1'b0;
        o_ld_B      = 1'b0;
        o_shift     = 1'b0;
        o_carry_clr = 1'b0;
        o_carry_en  = 1'b0;
        o_sum_shift = 1'b0;
        o_bit_idx   = '0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                o_ld_A      = 1'b1;
                o_ld_B      = 1'b1;
                o_carry_clr = 1'b1;
                o_busy      = 1'b1;
                w_cnt_clr   = 1'b1;
                w_next      = ST_ADD;
            end
            ST_ADD: begin
                o_shift     = 1'b1;
                o_carry_en  = 1'b1;
                o_sum_shift = 1'b1;
                o_busy      = 1'b1;
                o_bit_idx   = w_count;
                w_cnt_en    = 1'b1;
                if (w_tc) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done = 1'b1;
                o_busy = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cout <= 1'b0;
        end else if ((r_state == ST_ADD) && w_tc) begin
            r_cout <= i_carry_d;
        end
    end

    assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with a behavioural A/B/carry/sum datapath around it.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic       w_carry_d;
    logic       o_ld_A, o_ld_B, o_shift, o_carry_clr, o_carry_en, o_sum_shift;
    logic [2:0] o_bit_idx;
    logic       o_busy, o_done, o_cout;

    serial_add_ctrl #(.N(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (i_start),
        .i_carry_d   (w_carry_d),
        .o_ld_A      (o_ld_A),
        .o_ld_B      (o_ld_B),
        .o_shift     (o_shift),
        .o_carry_clr (o_carry_clr),
        .o_carry_en  (o_carry_en),
        .o_sum_shift (o_sum_shift),
        .o_bit_idx   (o_bit_idx),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_cout      (o_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: operand regs zero themselves when neither loaded nor shifted.
    logic [7:0] opA = '0, opB = '0;
    logic [7:0] mA = '0, mB = '0, mS = '0;
    logic       mC = 1'b0;
    logic       w_sbit;
    assign w_carry_d = (mA[0] & mB[0]) | (mC & (mA[0] ^ mB[0]));
    assign w_sbit    = mA[0] ^ mB[0] ^ mC;

    always @(posedge clk) begin
        if (o_ld_A) mA <= opA; else if (o_shift) mA <= mA >> 1; else mA <= '0;
        if (o_ld_B) mB <= opB; else if (o_shift) mB <= mB >> 1; else mB <= '0;
        if (o_carry_clr) mC <= 1'b0; else if (o_carry_en) mC <= w_carry_d;
        if (o_sum_shift) mS <= {w_sbit, mS[7:1]};
    end

    logic [10:0] w_vec;
    assign w_vec = {o_ld_A, o_ld_B, o_shift, o_carry_clr, o_carry_en, o_sum_shift,
                    o_busy, o_done, o_bit_idx};

    localparam logic [10:0] V_IDLE = 11'b00000000_000;
    localparam logic [10:0] V_LOAD = 11'b11010010_000;
    localparam logic [10:0] V_DONE = 11'b00000011_000;
    localparam logic [7:0]  V_ADDH = 8'b00101110;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int         dcyc;
        logic [7:0] sum;
        logic       cout;
    } exp_t;
    exp_t sb[$];

    // Monitor: pops an expectation whenever the DUT presents o_done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_busy) check("ld_shift_exclusive", 32'((o_ld_A | o_ld_B) & o_shift), 32'd0);
            if (o_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.dcyc));
                    check("sum", 32'(mS), 32'(e.sum));
                    check("cout_at_done", 32'(o_cout), 32'(e.cout));
                end
            end
        end
    end

    int t_last;

    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] s, input logic c, input bit expect_done);
        @(negedge clk);
        opA = a;
        opB = b;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        t_last = cyc;
        if (expect_done) sb.push_back('{cyc + 9, s, c});
        i_start = 1'b0;
    endtask

    // Called one step after the LOAD edge; checks the full control trace.
    task automatic run_trace();
        logic [2:0] k3;
        check("trace_load", 32'(w_vec), 32'(V_LOAD));
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            k3 = 3'(k);
            check("trace_add", 32'(w_vec), 32'({V_ADDH, k3}));
        end
        @(posedge clk);
        #1;
        check("trace_done", 32'(w_vec), 32'(V_DONE));
        @(posedge clk);
        #1;
        check("trace_idle_after", 32'(w_vec), 32'(V_IDLE));
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 100 && cyc != target; i++) @(negedge clk);
        if (cyc != target) check("wait_cyc_timeout", 32'(cyc), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t;
        int  t0;
        bit  found;
        rst_n   = 1'b0;
        i_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("idle_vec", 32'(w_vec), 32'(V_IDLE));
        end
        check("idle_cout", 32'(o_cout), 32'd0);

        issue(8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
        run_trace();
        repeat (5) @(posedge clk);
        #1;
        check("cout_hold_1", 32'(o_cout), 32'd1);

        issue(8'h35, 8'h4C, 8'h81, 1'b0, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        check("cout_hold_0", 32'(o_cout), 32'd0);

        // Start pulses while busy (mid-ADD and during DONE) must be ignored.
        issue(8'hAA, 8'h55, 8'hFF, 1'b0, 1'b1);
        t = t_last;
        wait_cyc(t + 2);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_cyc(t + 9);
        check("done_visible", 32'(o_done), 32'd1);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        check("busy_after_done_start", 32'(o_busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("no_load_after_ignored", 32'(w_vec), 32'(V_IDLE));
        end

        // Back-to-back: start held for 40 sampling edges.
        @(negedge clk);
        opA = 8'h80;
        opB = 8'h80;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        check("b2b_first_load", 32'(w_vec), 32'(V_LOAD));
        for (int j = 0; j < 4; j++) sb.push_back('{t0 + 9 + 11 * j, 8'h00, 1'b1});
        for (int i = 0; i < 39; i++) begin
            @(posedge clk);
            #1;
            if (cyc == t0 + 10) check("b2b_idle_gap", 32'(o_busy), 32'd0);
            if (cyc == t0 + 11) check("b2b_reload", 32'(w_vec), 32'(V_LOAD));
        end
        i_start = 1'b0;
        wait_cyc(t0 + 46);
        check("b2b_idle_end", 32'(o_busy), 32'd0);

        // Asynchronous reset in the middle of ADD.
        issue(8'h12, 8'h34, 8'h46, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (o_bit_idx == 3'd4 && o_shift) found = 1'b1;
        end
        check("reach_idx4", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_vec", 32'(w_vec), 32'(V_IDLE));
        check("abort_cout", 32'(o_cout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_idle", 32'(w_vec), 32'(V_IDLE));

        issue(8'h12, 8'h34, 8'h46, 1'b0, 1'b1);
        run_trace();
        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
